// File: rtl/nlfsr_seq_ctrl_if.sv
// Readout handshake between the NLFSR sequencer and the post-processing side.
interface nlfsr_seq_ctrl_if #(
  parameter int unsigned OUT_W = 8
);
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/nlfsr_seq_ctrl.sv
// Sequencer for a 17-stage NLFSR entropy core: seed load, warbler init, bit harvest.
// Optional repetition-count health test enabled by defining NLFSR_SEQ_HEALTH_EN.
module nlfsr_seq_ctrl #(
  parameter int unsigned SEED_W      = 17,
  parameter int unsigned INIT_CYCLES = 64,
  parameter int unsigned OUT_W       = 8
`ifdef NLFSR_SEQ_HEALTH_EN
  , parameter int unsigned RCT_LIMIT = 32
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [SEED_W-1:0] seed,
  input  logic              a0,
  output logic              load,
  output logic              d1,
  output logic              init,
  output logic              nlfsr3_ce,
  nlfsr_seq_ctrl_if.master  rd,
  output logic              busy,
  output logic              drop,
  output logic              running
`ifdef NLFSR_SEQ_HEALTH_EN
  , output logic            health_fail
`endif
);

  localparam int unsigned PH_MAX = (SEED_W > INIT_CYCLES) ? SEED_W : INIT_CYCLES;
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int unsigned CNT_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
`ifdef NLFSR_SEQ_HEALTH_EN
  localparam int unsigned RL_W   = $clog2(RCT_LIMIT + 1);
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_INIT, ST_RUN} state_t;

  state_t             state_q, state_d;
  logic [PH_W-1:0]    ph_q, ph_d;
  logic [SEED_W-1:0]  sreg_q, sreg_d;
  logic [OUT_W-1:0]   coll_q, coll_d, word_c;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               drop_q, drop_d;
  logic               load_q, load_d, d1_q, d1_d, init_q, init_d;
  logic               nce_q, nce_d, run_q, run_d;
`ifdef NLFSR_SEQ_HEALTH_EN
  logic [RL_W-1:0]    rl_q, rl_d;
  logic               last_q, last_d, hf_q, hf_d;
`endif

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    sreg_d  = sreg_q;
    coll_d  = coll_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    drop_d  = drop_q;
    load_d  = 1'b0;
    d1_d    = 1'b0;
    init_d  = 1'b0;
    nce_d   = 1'b0;
    run_d   = 1'b0;
    word_c  = coll_q;
    word_c[cnt_q] = a0;
`ifdef NLFSR_SEQ_HEALTH_EN
    rl_d    = rl_q;
    last_d  = last_q;
    hf_d    = hf_q;
`endif
    if (valid_q && rd.out_ready) valid_d = 1'b0;

    if (state_q != ST_IDLE && stop) begin
      state_d = ST_IDLE;
      ph_d    = '0;
      cnt_d   = '0;
      coll_d  = '0;
`ifdef NLFSR_SEQ_HEALTH_EN
      rl_d    = '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !stop) begin
            state_d = ST_LOAD;
            ph_d    = '0;
            sreg_d  = seed >> 1;
            d1_d    = seed[0];
            load_d  = 1'b1;
            drop_d  = 1'b0;
            cnt_d   = '0;
            coll_d  = '0;
`ifdef NLFSR_SEQ_HEALTH_EN
            rl_d    = '0;
            hf_d    = 1'b0;
`endif
          end
        end
        ST_LOAD: begin
          if (ph_q == PH_W'(SEED_W - 1)) begin
            state_d = ST_INIT;
            ph_d    = '0;
            init_d  = 1'b1;
            nce_d   = 1'b1;
          end else begin
            ph_d   = ph_q + PH_W'(1);
            load_d = 1'b1;
            d1_d   = sreg_q[0];
            sreg_d = sreg_q >> 1;
          end
        end
        ST_INIT: begin
          if (ph_q == PH_W'(INIT_CYCLES - 1)) begin
            state_d = ST_RUN;
            ph_d    = '0;
            run_d   = 1'b1;
          end else begin
            ph_d   = ph_q + PH_W'(1);
            init_d = 1'b1;
            nce_d  = 1'b1;
          end
        end
        ST_RUN: begin
          run_d = 1'b1;
          // A completed word goes to the output register unless it is still occupied
          if (cnt_q == CNT_W'(OUT_W - 1)) begin
            cnt_d  = '0;
            coll_d = '0;
            if (!valid_q || rd.out_ready) begin
              data_d  = word_c;
              valid_d = 1'b1;
            end else begin
              drop_d = 1'b1;
            end
          end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            coll_d = word_c;
          end
`ifdef NLFSR_SEQ_HEALTH_EN
          last_d = a0;
          rl_d   = (rl_q != '0 && a0 == last_q) ? rl_q + RL_W'(1) : RL_W'(1);
          if (rl_d == RL_W'(RCT_LIMIT)) begin
            state_d = ST_IDLE;
            run_d   = 1'b0;
            hf_d    = 1'b1;
            cnt_d   = '0;
            coll_d  = '0;
            rl_d    = '0;
          end
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ph_q    <= '0;
      sreg_q  <= '0;
      coll_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
      load_q  <= 1'b0;
      d1_q    <= 1'b0;
      init_q  <= 1'b0;
      nce_q   <= 1'b0;
      run_q   <= 1'b0;
`ifdef NLFSR_SEQ_HEALTH_EN
      rl_q    <= '0;
      last_q  <= 1'b0;
      hf_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      sreg_q  <= sreg_d;
      coll_q  <= coll_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
      load_q  <= load_d;
      d1_q    <= d1_d;
      init_q  <= init_d;
      nce_q   <= nce_d;
      run_q   <= run_d;
`ifdef NLFSR_SEQ_HEALTH_EN
      rl_q    <= rl_d;
      last_q  <= last_d;
      hf_q    <= hf_d;
`endif
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign load         = load_q;
  assign d1           = d1_q;
  assign init         = init_q;
  assign nlfsr3_ce    = nce_q;
  assign running      = run_q;
  assign drop         = drop_q;
  assign rd.out_data  = data_q;
  assign rd.out_valid = valid_q;
`ifdef NLFSR_SEQ_HEALTH_EN
  assign health_fail  = hf_q;
`endif

endmodule
